// File: rtl/mem_cdb_wb_queue.sv
// MEM-port writeback queue for the common data bus: in-order FIFO of completed MEM
// writebacks, head presented on *_MEM_CDB and held until a cycle without an ALU write.
module mem_cdb_wb_queue #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           Valid_MEM_WB,
   input  logic           RegWrite_MEM_WB,
   input  logic [2:0]     WarpID_MEM_WB,
   input  logic [4:0]     Dst_MEM_WB,
   input  logic [255:0]   Dst_Data_MEM_WB,
   input  logic [31:0]    Instr_MEM_WB,
   input  logic [7:0]     ActiveMask_MEM_WB,
   input  logic [1:0]     ScbID_MEM_WB,
   input  logic           RegWrite_ALU_CDB,
   output logic           Stall_WB_MEM,
   output logic           RegWrite_MEM_CDB,
   output logic [2:0]     WarpID_MEM_CDB,
   output logic [4:0]     Dst_MEM_CDB,
   output logic [255:0]   Dst_Data_MEM_CDB,
   output logic [31:0]    Instr_MEM_CDB,
   output logic [7:0]     ActiveMask_MEM_CDB,
   output logic [1:0]     Clear_ScbID_MEM_CDB,
   output logic [PTR_W:0] Count_WBQ,
   output logic           Overflow_WBQ
);

   typedef struct packed {
      logic [2:0]   warp;
      logic [4:0]   dst;
      logic [255:0] data;
      logic [31:0]  instr;
      logic [7:0]   mask;
      logic [1:0]   scb;
   } entry_t;

   localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE  = 1;
   localparam logic [PTR_W-1:0] PTR_ONE  = 1;

   entry_t           mem_q [DEPTH];
   entry_t           mem_d [DEPTH];
   logic [DEPTH-1:0] vld_q, vld_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             overflow_q, overflow_d;

   logic   full, req, push, pop;
   entry_t wr_entry, head;

   always_comb begin
      mem_d      = mem_q;
      vld_d      = vld_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;

      full = (count_q == FULL_CNT);
      req  = Valid_MEM_WB & RegWrite_MEM_WB;
      // A full queue refuses the push even when the head drains this same cycle.
      push = req & ~full;
      pop  = (count_q != '0) & ~RegWrite_ALU_CDB;

      wr_entry = '{warp: WarpID_MEM_WB, dst: Dst_MEM_WB, data: Dst_Data_MEM_WB,
                   instr: Instr_MEM_WB, mask: ActiveMask_MEM_WB, scb: ScbID_MEM_WB};

      if (push) begin
         mem_d[wr_ptr_q] = wr_entry;
         vld_d[wr_ptr_q] = 1'b1;
         wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
         vld_d[rd_ptr_q] = 1'b0;
         rd_ptr_d        = rd_ptr_q + PTR_ONE;
      end

      unique case ({push, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase

      if (req & full) overflow_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         vld_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         mem_q      <= mem_d;
         vld_q      <= vld_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   always_comb begin
      head = vld_q[rd_ptr_q] ? mem_q[rd_ptr_q] : '0;
   end

   assign RegWrite_MEM_CDB    = (count_q != '0);
   assign WarpID_MEM_CDB      = head.warp;
   assign Dst_MEM_CDB         = head.dst;
   assign Dst_Data_MEM_CDB    = head.data;
   assign Instr_MEM_CDB       = head.instr;
   assign ActiveMask_MEM_CDB  = head.mask;
   assign Clear_ScbID_MEM_CDB = head.scb;
   assign Stall_WB_MEM        = full;
   assign Count_WBQ           = count_q;
   assign Overflow_WBQ        = overflow_q;

endmodule
